// File: rtl/panda_risc_v_reset_seq.sv
// Reset sequencer: filters the board reset, holds domains on software requests,
// releases domains in staggered order and records the cause of the last reset.
module panda_risc_v_reset_seq #(
    parameter int simulation_delay = 1,
    parameter int FILTER_PERIOD_N  = 4,
    parameter int RELEASE_DELAY_N  = 4,
    parameter int DOMAIN_N         = 3,
    parameter int DOMAIN_STAGGER_N = 2,
    parameter int SW_RST_N         = 2,
    parameter int SW_HOLD_N        = 8
) (
    input  logic                clk,
    input  logic                ext_resetn,
    input  logic [SW_RST_N-1:0] sw_reset,
    output logic [DOMAIN_N-1:0] sys_resetn,
    output logic                sys_reset_req,
    output logic [SW_RST_N:0]   reset_cause,
    output logic                rst_busy
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = max2(max2(FILTER_PERIOD_N, RELEASE_DELAY_N),
                                  max2(DOMAIN_STAGGER_N, SW_HOLD_N));
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_PERIOD_N - 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(RELEASE_DELAY_N - 1);
    localparam logic [CNT_W-1:0] STG_LAST  = CNT_W'(DOMAIN_STAGGER_N - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(SW_HOLD_N);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [SW_RST_N:0] CAUSE_EXT = {{SW_RST_N{1'b0}}, 1'b1};

    // simulation_delay is kept for drop-in compatibility; registered updates are zero-delay.
    if (simulation_delay < 0 || FILTER_PERIOD_N < 1 || RELEASE_DELAY_N < 1 ||
        DOMAIN_N < 1 || DOMAIN_N > 8 || DOMAIN_STAGGER_N < 1 ||
        SW_RST_N < 1 || SW_RST_N > 8 || SW_HOLD_N < 1) begin : g_bad_params
    end

    typedef enum logic [2:0] {
        ST_FILTER  = 3'd0,
        ST_HOLD    = 3'd1,
        ST_DELAY   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          sync_q;
    logic [DOMAIN_N-1:0] resetn_q, resetn_d;
    logic [SW_RST_N:0]   cause_q, cause_d;
    logic                req_q, req_d;
    logic                busy_q, busy_d;
    logic                ext_sync_s;
    logic                sw_any_s;
    logic [SW_RST_N:0]   sw_cause_s;
    logic [DOMAIN_N-1:0] resetn_next_s;

    assign ext_sync_s    = sync_q[1];
    assign sw_any_s      = |sw_reset;
    assign sw_cause_s    = {sw_reset, 1'b0};
    // Domains fill from bit 0 upward, so the next mask shifts a one in at the bottom.
    assign resetn_next_s = DOMAIN_N'({resetn_q, 1'b1});

    // Two-flop synchroniser for the release edge of the external reset.
    always_ff @(posedge clk or negedge ext_resetn) begin
        if (!ext_resetn) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    // Sequencer state, counter and registered outputs.
    always_ff @(posedge clk or negedge ext_resetn) begin
        if (!ext_resetn) begin
            state_q  <= ST_FILTER;
            cnt_q    <= '0;
            resetn_q <= '0;
            cause_q  <= CAUSE_EXT;
            req_q    <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            resetn_q <= resetn_d;
            cause_q  <= cause_d;
            req_q    <= req_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        resetn_d = resetn_q;
        cause_d  = cause_q;
        case (state_q)
            ST_FILTER: begin
                if (ext_sync_s) begin
                    if (cnt_q >= FILT_LAST) begin
                        state_d = ST_DELAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_HOLD: begin
                resetn_d = '0;
                if (sw_any_s) begin
                    cnt_d   = HOLD_LOAD;
                    cause_d = cause_q | sw_cause_s;
                end else if (cnt_q <= CNT_ONE) begin
                    state_d = ST_DELAY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DELAY: begin
                if (sw_any_s) begin
                    state_d  = ST_HOLD;
                    cnt_d    = HOLD_LOAD;
                    resetn_d = '0;
                    cause_d  = cause_q | sw_cause_s;
                end else if (cnt_q >= DLY_LAST) begin
                    cnt_d    = '0;
                    resetn_d = resetn_next_s;
                    // With a single domain the first release is also the last.
                    state_d  = (DOMAIN_N == 1) ? ST_RUN : ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RELEASE: begin
                if (sw_any_s) begin
                    state_d  = ST_HOLD;
                    cnt_d    = HOLD_LOAD;
                    resetn_d = '0;
                    cause_d  = cause_q | sw_cause_s;
                end else if (cnt_q >= STG_LAST) begin
                    cnt_d    = '0;
                    resetn_d = resetn_next_s;
                    if (resetn_next_s[DOMAIN_N-1]) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (sw_any_s) begin
                    state_d  = ST_HOLD;
                    cnt_d    = HOLD_LOAD;
                    resetn_d = '0;
                    cause_d  = sw_cause_s;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d  = ST_FILTER;
                cnt_d    = '0;
                resetn_d = '0;
            end
        endcase
        // busy_q is still high only on the first cycle in RUN, which is where the pulse belongs.
        req_d  = (state_q == ST_RUN) && busy_q && (state_d == ST_RUN);
        busy_d = (state_q != ST_RUN);
    end

    assign sys_resetn    = resetn_q;
    assign sys_reset_req = req_q;
    assign reset_cause   = cause_q;
    assign rst_busy      = busy_q;

endmodule
